// File: rtl/mem_arbiter_pkg.sv
// Purpose : shared widths, port indices, FSM encodings and helpers for the memory arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Width and port-index macros. Other memory-subsystem blocks expect these
// names, so each one is guarded and an earlier definition takes precedence.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef PORT_CPU
`define PORT_CPU 1'b0
`endif
`ifndef PORT_DMA
`define PORT_DMA 1'b1
`endif

package mem_arbiter_pkg;

  localparam int WORD_W = `WORD_SIZE;
  localparam int ADDR_W = `ADDR_SIZE;

  // FSM encodings. They are fixed so that state dumps stay readable across tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1,
    TURN = ST_TURN
  } arb_state_t;

  // A requester index: 0 is the cpu port and 1 is the dma/io port.
  typedef logic port_t;

  // Ownership state that corresponds to a requester index.
  function automatic arb_state_t own_state(input port_t port);
    return (port == `PORT_DMA) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Purpose : 2-way round-robin pick. It chooses the requester that did not own the bus last.
// Latency : combinational, 0 cycles.
// Backpressure: none. The caller samples the pick only when it is ready to grant.
//
// Ports:
//   req0/req1 : requests currently pending
//   last      : index of the previous owner
//   pick_vld  : at least one request is pending
//   pick      : index of the chosen requester (valid only when pick_vld)
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last,
  output logic  pick_vld,
  output port_t pick
);

  assign pick_vld = req0 | req1;

  // On a tie, the port that did not own the bus last wins.
  // With a single requester, that requester is picked.
  assign pick = (req0 & req1) ? port_t'(~last) : port_t'(req1);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port synchronous memory between cpu (port 0) and dma/io (port 1).
// Latency : grant 1 cycle after the owner state is entered; read data 1 cycle after the access.
// Backpressure: a requester holds req until granted. A waiting request that drops is forgotten.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   req*/lock*         : per-port request and quantum-yield suppression
//   we*/addr*/wdata*   : per-port access command
//   gnt*               : registered grant (one-hot or zero)
//   rvalid*, rdata     : per-port read-return strobe and shared read data
//   mem_en/we/addr/wdata, mem_rdata : single-port memory interface
//   preempt            : one-cycle pulse on a forced release at the MAX_LOCK tenure limit
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int QUANTUM  = 4,   // accesses before yielding to a waiting, unlocked competitor
  parameter int MAX_LOCK = 16,  // hard tenure limit, applied even while locked
  parameter int CNT_W    = 5    // tenure counter width; needs QUANTUM <= MAX_LOCK < 2**CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              preempt
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  port_t            last;

  logic  pick_vld;
  port_t pick;

  arb_rr2 u_rr (
    .req0     (req0),
    .req1     (req1),
    .last     (last),
    .pick_vld (pick_vld),
    .pick     (pick)
  );

  // An access is any cycle in which a port holds both grant and request.
  logic acc0, acc1;
  assign acc0 = gnt0 & req0;
  assign acc1 = gnt1 & req1;

  // Signals seen from the current owner's point of view. In IDLE and TURN
  // they default to port 0, but nothing reads them in those states.
  port_t own_port;
  logic  own_req, own_lock, own_gnt, oth_req, own_acc;
  always_comb begin
    own_port = port_t'(state == OWN1);
    own_req  = own_port ? req1  : req0;
    own_lock = own_port ? lock1 : lock0;
    own_gnt  = own_port ? gnt1  : gnt0;
    oth_req  = own_port ? req0  : req1;
    own_acc  = own_gnt & own_req;
  end

  // cnt holds the number of accesses completed before this cycle, so the
  // access under way is number cnt+1 of the tenure.
  logic at_quantum, at_max;
  assign at_quantum = (cnt == CNT_W'(QUANTUM - 1));
  assign at_max     = (cnt == CNT_W'(MAX_LOCK - 1));

  // The tenure ends in three cases:
  //   - the owner drops its request, including during the wait cycle before gnt rises;
  //   - the quantum expires while an unlocked owner has a waiting competitor;
  //   - the hard limit is reached, whatever the lock or competitor.
  logic tenure_end;
  assign tenure_end = !own_req |
                      (own_acc & (at_max | (oth_req & ~own_lock & at_quantum)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      preempt <= 1'b0;
      cnt     <= '0;
      last    <= `PORT_DMA;
    end else begin
      // Read returns follow the access whatever happens to the grant, so a
      // read on the final access of a tenure is still answered.
      rvalid0 <= acc0 & ~we0;
      rvalid1 <= acc1 & ~we1;
      preempt <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_vld) state <= own_state(pick);
        end

        OWN0, OWN1: begin
          if (tenure_end) begin
            state   <= TURN;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            last    <= own_port;
            preempt <= own_acc & at_max;
          end else if (own_acc) begin
            cnt <= cnt + 1'b1;
          end else begin
            // First cycle in the owner state: raise the grant for the next cycle.
            gnt0 <= (own_port == `PORT_CPU);
            gnt1 <= (own_port == `PORT_DMA);
          end
        end

        TURN: begin
          cnt   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The memory command comes straight from the owner's inputs, so an owner can
  // issue a new access every cycle. When no access is taking place the memory
  // interface is held at zero.
  always_comb begin
    mem_en    = acc0 | acc1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (acc1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int QUANTUM  = 4;
  localparam int MAX_LOCK = 16;
  localparam int N_RAND   = 10000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0, req1, lock0, lock1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [WORD_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, preempt;
  logic [WORD_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.QUANTUM(QUANTUM), .MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .preempt(preempt)
  );

  // Memory model: single port, synchronous read, loaded with a known pattern.
  function automatic logic [WORD_W-1:0] pre_val(input int a);
    return WORD_W'(a * 37 + 'h1200);
  endfunction

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= pre_val(i);
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Reference contents, updated only from the accesses the bench itself issued.
  logic [WORD_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Holds reset for two edges and checks the reset state. Reset is released at
  // posedge+1, and the caller sets the cycle-0 inputs right after.
  task automatic do_reset(input string tag);
    rst = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    chk1({tag, "_rst_gnt0"}, gnt0, 1'b0);
    chk1({tag, "_rst_gnt1"}, gnt1, 1'b0);
    chk1({tag, "_rst_rvalid0"}, rvalid0, 1'b0);
    chk1({tag, "_rst_rvalid1"}, rvalid1, 1'b0);
    chk1({tag, "_rst_preempt"}, preempt, 1'b0);
    chk1({tag, "_rst_mem_en"}, mem_en, 1'b0);
    chkw({tag, "_rst_mem_addr"}, 32'(mem_addr), 32'h0);
    rst = 1;
  endtask

  // Random-phase bookkeeping: previous-cycle values and per-tenure access counts.
  logic pg0, pg1, preq0, preq1, plock0, plock1, exp_rv0, exp_rv1, acc0, acc1, keep;
  logic [WORD_W-1:0] exp_rd0, exp_rd1;
  int tcnt0, tcnt1, rd_cnt, rv_cnt, tenures;

  initial begin
    idle_inputs();
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = pre_val(i);

    // 1: port 0 alone, three reads at 0x10, 0x12 and 0x14.
    do_reset("t1");
    req0 = 1; addr0 = 8'h10;
    for (int c = 0; c <= 6; c++) begin
      #4;
      chk1("t1_gnt0", gnt0, (c >= 2 && c <= 5));
      chk1("t1_gnt1", gnt1, 1'b0);
      chk1("t1_mem_en", mem_en, (c >= 2 && c <= 4));
      chkw("t1_mem_addr", 32'(mem_addr), (c >= 2 && c <= 4) ? 32'(16 + 2 * (c - 2)) : 32'h0);
      chk1("t1_rvalid0", rvalid0, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) chkw("t1_rdata", 32'(rdata), 32'(pre_val(16 + 2 * (c - 3))));
      next_cycle();
      req0 = (c + 1 <= 4);
      if (c + 1 >= 2 && c + 1 <= 4) addr0 = ADDR_W'(16 + 2 * (c - 1));
    end

    // 2: both ports request together. Port 0 gets the quantum, then TURN, then port 1.
    do_reset("t2");
    req0 = 1; req1 = 1; addr0 = 8'h30; addr1 = 8'h40;
    for (int c = 0; c <= 10; c++) begin
      #4;
      chk1("t2_gnt0", gnt0, (c >= 2 && c <= 5));
      chk1("t2_gnt1", gnt1, (c >= 9));
      chk1("t2_mem_en", mem_en, (c >= 2 && c <= 5) || c >= 9);
      next_cycle();
    end

    // 3: locked port 1 with port 0 waiting. Forced release after MAX_LOCK accesses.
    do_reset("t3");
    req1 = 1; lock1 = 1; addr1 = 8'h50;
    for (int c = 0; c <= 22; c++) begin
      #4;
      chk1("t3_gnt1", gnt1, (c >= 2 && c <= 17));
      chk1("t3_gnt0", gnt0, (c >= 21));
      chk1("t3_preempt", preempt, (c == 18));
      next_cycle();
      if (c + 1 == 3) req0 = 1;
    end

    // 4: port 0 writes 0xBEEF at 0x20 and releases. Port 1 reads it back.
    do_reset("t4");
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'hBEEF; addr1 = 8'h20;
    for (int c = 0; c <= 9; c++) begin
      #4;
      chk1("t4_gnt0", gnt0, (c >= 2 && c <= 3));
      chk1("t4_gnt1", gnt1, (c >= 7 && c <= 8));
      chk1("t4_mem_we", mem_we, (c == 2));
      if (c == 2) chkw("t4_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      chk1("t4_rvalid1", rvalid1, (c == 8));
      chk1("t4_rvalid0", rvalid0, 1'b0);
      if (c == 8) chkw("t4_rdata", 32'(rdata), 32'hBEEF);
      next_cycle();
      req0 = (c + 1 <= 2);
      req1 = (c + 1 >= 3 && c + 1 <= 7);
    end
    ref_mem[8'h20] = 16'hBEEF;

    // 5: asynchronous reset during a tenure while a read is in flight.
    do_reset("t5");
    req0 = 1; addr0 = 8'h16;
    for (int c = 0; c <= 3; c++) begin
      #4;
      chk1("t5_pre_gnt0", gnt0, (c >= 2));
      next_cycle();
    end
    #4;
    chk1("t5_inflight_rvalid0", rvalid0, 1'b1);
    chk1("t5_inflight_gnt0", gnt0, 1'b1);
    #1 rst = 0;
    #1;
    chk1("t5_async_gnt0", gnt0, 1'b0);
    chk1("t5_async_gnt1", gnt1, 1'b0);
    chk1("t5_async_rvalid0", rvalid0, 1'b0);
    chk1("t5_async_mem_en", mem_en, 1'b0);
    chk1("t5_async_preempt", preempt, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1; req0 = 1; req1 = 1; addr1 = 8'h18;
    for (int c = 0; c <= 3; c++) begin
      #4;
      chk1("t5_restart_gnt0", gnt0, (c >= 2));
      chk1("t5_restart_gnt1", gnt1, 1'b0);
      chk1("t5_restart_rvalid0", rvalid0, (c == 3));
      next_cycle();
    end

    // 6: random traffic checked against the arbitration rules.
    do_reset("t6");
    pg0 = 0; pg1 = 0; preq0 = 0; preq1 = 0; plock0 = 0; plock1 = 0;
    exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = '0; exp_rd1 = '0;
    tcnt0 = 0; tcnt1 = 0; rd_cnt = 0; rv_cnt = 0; tenures = 0;
    for (int c = 0; c < N_RAND; c++) begin
      // Stimulus. An owner holds req for a random tenure. A waiter may give up.
      if (gnt0)      req0 = req0 && ($urandom_range(0, 11) != 0);
      else if (req0) req0 = ($urandom_range(0, 15) != 0);
      else           req0 = ($urandom_range(0, 3) == 0);
      if (gnt1)      req1 = req1 && ($urandom_range(0, 11) != 0);
      else if (req1) req1 = ($urandom_range(0, 15) != 0);
      else           req1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) lock0 = ~lock0;
      if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
      we0 = $urandom_range(0, 1) != 0;
      we1 = $urandom_range(0, 1) != 0;
      addr0 = ADDR_W'($urandom_range(0, 63));
      addr1 = ADDR_W'($urandom_range(0, 63));
      wdata0 = WORD_W'($urandom);
      wdata1 = WORD_W'($urandom);
      #4;

      chk1("rnd_onehot", gnt0 & gnt1, 1'b0);
      chk1("rnd_turn_gap", (gnt0 & pg1) | (gnt1 & pg0), 1'b0);

      if (pg0) begin
        keep = preq0 && tcnt0 != MAX_LOCK && !(tcnt0 == QUANTUM && preq1 && !plock0);
        chk1("rnd_tenure0", gnt0, keep);
      end else if (gnt0) begin
        chk1("rnd_rise0_needs_req", preq0, 1'b1);
      end
      if (pg1) begin
        keep = preq1 && tcnt1 != MAX_LOCK && !(tcnt1 == QUANTUM && preq0 && !plock1);
        chk1("rnd_tenure1", gnt1, keep);
      end else if (gnt1) begin
        chk1("rnd_rise1_needs_req", preq1, 1'b1);
      end
      chk1("rnd_preempt", preempt,
           (pg0 && preq0 && tcnt0 == MAX_LOCK) || (pg1 && preq1 && tcnt1 == MAX_LOCK));

      chk1("rnd_rvalid0", rvalid0, exp_rv0);
      chk1("rnd_rvalid1", rvalid1, exp_rv1);
      if (exp_rv0) chkw("rnd_rdata0", 32'(rdata), 32'(exp_rd0));
      if (exp_rv1) chkw("rnd_rdata1", 32'(rdata), 32'(exp_rd1));
      rv_cnt += int'(rvalid0) + int'(rvalid1);

      acc0 = gnt0 & req0;
      acc1 = gnt1 & req1;
      chk1("rnd_mem_en", mem_en, acc0 | acc1);
      chk1("rnd_mem_we", mem_we, acc0 ? we0 : (acc1 ? we1 : 1'b0));
      chkw("rnd_mem_addr", 32'(mem_addr), acc0 ? 32'(addr0) : (acc1 ? 32'(addr1) : 32'h0));
      chkw("rnd_mem_wdata", 32'(mem_wdata), acc0 ? 32'(wdata0) : (acc1 ? 32'(wdata1) : 32'h0));

      if (gnt0 && !pg0) tenures++;
      if (gnt1 && !pg1) tenures++;
      if (!gnt0) tcnt0 = 0;
      if (!gnt1) tcnt1 = 0;
      if (acc0) tcnt0++;
      if (acc1) tcnt1++;

      exp_rv0 = acc0 && !we0;
      exp_rv1 = acc1 && !we1;
      if (exp_rv0) begin exp_rd0 = ref_mem[addr0]; rd_cnt++; end
      if (exp_rv1) begin exp_rd1 = ref_mem[addr1]; rd_cnt++; end
      if (acc0 && we0) ref_mem[addr0] = wdata0;
      if (acc1 && we1) ref_mem[addr1] = wdata1;

      pg0 = gnt0; pg1 = gnt1; preq0 = req0; preq1 = req1;
      plock0 = lock0; plock1 = lock1;
      next_cycle();
    end
    idle_inputs();
    #4;
    rv_cnt += int'(rvalid0) + int'(rvalid1);
    chkw("rnd_rvalid_count", 32'(rv_cnt), 32'(rd_cnt));
    chk1("rnd_activity", tenures > 10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
